// File: rtl/blinds_ctrl.sv
// Roller-blind position sequencer: arbitrates manual/automatic requests and steps {a,b} one quarter at a time.
// Optional obstruction abort (obstruct input, fault output) is enabled with `define BLINDS_OBSTRUCT_EN.
module blinds_ctrl #(
    parameter int STEP_CYCLES = 8,
    parameter int CNT_W       = 16
) (
    input  logic       clk,
    input  logic       rst_n,
`ifdef BLINDS_OBSTRUCT_EN
    input  logic       obstruct,
    output logic       fault,
`endif
    input  logic       man_req,
    input  logic [1:0] man_pos,
    input  logic       auto_req,
    input  logic [1:0] auto_pos,
    output logic       man_ack,
    output logic       auto_ack,
    output logic       a,
    output logic       b,
    output logic       moving,
    output logic       dir_up,
    output logic       done
);

    typedef enum logic [1:0] {IDLE, MOVE, DONE} state_t;

    localparam logic [CNT_W-1:0] LAST_TICK = CNT_W'(STEP_CYCLES - 1);

    state_t           state_reg, state_next;
    logic [1:0]       pos_reg, pos_next;
    logic [1:0]       target_reg, target_next;
    logic [CNT_W-1:0] timer_reg, timer_next;
    logic             dir_reg, dir_next;
    logic             man_ack_reg, man_ack_next;
    logic             auto_ack_reg, auto_ack_next;
    logic [1:0]       tgt;
    logic [1:0]       step_pos;
    logic             abort;

`ifdef BLINDS_OBSTRUCT_EN
    logic fault_reg, fault_next;
    assign abort = obstruct;
    assign fault = fault_reg;
`else
    assign abort = 1'b0;
`endif

    always_comb begin
        state_next    = state_reg;
        pos_next      = pos_reg;
        target_next   = target_reg;
        timer_next    = timer_reg;
        dir_next      = dir_reg;
        man_ack_next  = 1'b0;
        auto_ack_next = 1'b0;
        tgt           = target_reg;
        step_pos      = pos_reg;
`ifdef BLINDS_OBSTRUCT_EN
        fault_next    = fault_reg;
`endif
        case (state_reg)
            IDLE: begin
                if (man_req || auto_req) begin
                    if (man_req) begin
                        man_ack_next = 1'b1;
                        tgt          = man_pos;
                    end else begin
                        auto_ack_next = 1'b1;
                        tgt           = auto_pos;
                    end
                    target_next = tgt;
`ifdef BLINDS_OBSTRUCT_EN
                    fault_next  = 1'b0;
`endif
                    if (tgt == pos_reg) begin
                        state_next = DONE;
                    end else begin
                        state_next = MOVE;
                        timer_next = '0;
                        dir_next   = (tgt > pos_reg);
                    end
                end
            end
            MOVE: begin
                // Manual override retargets immediately; the ack cycle itself is not re-sampled.
                if (man_req && !man_ack_reg) begin
                    man_ack_next = 1'b1;
                    tgt          = man_pos;
                    target_next  = man_pos;
`ifdef BLINDS_OBSTRUCT_EN
                    fault_next   = 1'b0;
`endif
                end
                if (abort) begin
                    state_next = IDLE;
                    timer_next = '0;
`ifdef BLINDS_OBSTRUCT_EN
                    fault_next = 1'b1;
`endif
                end else if (timer_reg == LAST_TICK) begin
                    timer_next = '0;
                    step_pos   = dir_reg ? pos_reg + 2'd1 : pos_reg - 2'd1;
                    pos_next   = step_pos;
                    if (step_pos == tgt) begin
                        state_next = DONE;
                    end else begin
                        dir_next = (tgt > step_pos);
                    end
                end else begin
                    timer_next = timer_reg + 1'b1;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= IDLE;
            pos_reg      <= 2'd0;
            target_reg   <= 2'd0;
            timer_reg    <= '0;
            dir_reg      <= 1'b0;
            man_ack_reg  <= 1'b0;
            auto_ack_reg <= 1'b0;
        end else begin
            state_reg    <= state_next;
            pos_reg      <= pos_next;
            target_reg   <= target_next;
            timer_reg    <= timer_next;
            dir_reg      <= dir_next;
            man_ack_reg  <= man_ack_next;
            auto_ack_reg <= auto_ack_next;
        end
    end

`ifdef BLINDS_OBSTRUCT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fault_reg <= 1'b0;
        end else begin
            fault_reg <= fault_next;
        end
    end
`endif

    assign a        = pos_reg[1];
    assign b        = pos_reg[0];
    assign moving   = (state_reg == MOVE);
    assign done     = (state_reg == DONE);
    assign dir_up   = dir_reg;
    assign man_ack  = man_ack_reg;
    assign auto_ack = auto_ack_reg;

endmodule
